// File: rtl/bcd_chain_timer_if.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_chain_timer_if
//  Purpose  : Control and data bundle of the BCD chain timer. The master side
//             (prescaler / host) drives tick, direction, clear and load; the
//             slave side (the timer) returns the BCD count, the wrap pulse and
//             the zero flag.
//  Revision : 1.0 - initial release
// ============================================================================
interface bcd_chain_timer_if #(
    parameter int PAIRS = 2
);
    logic                 tick;
    logic                 up;
    logic                 clear;
    logic                 load;
    logic [8*PAIRS-1:0]   load_val;
    logic [8*PAIRS-1:0]   bcd;
    logic                 wrap;
    logic                 zero;

    modport master (
        output tick,
        output up,
        output clear,
        output load,
        output load_val,
        input  bcd,
        input  wrap,
        input  zero
    );

    modport slave (
        input  tick,
        input  up,
        input  clear,
        input  load,
        input  load_val,
        output bcd,
        output wrap,
        output zero
    );
endinterface
`default_nettype wire

// File: rtl/bcd_chain_timer.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_chain_timer
//  Purpose  : Synchronous N-pair BCD up/down timer (mm:ss, hh:mm:ss, ...).
//             Digits advance on a qualified tick enable; carries and borrows
//             ripple combinationally through the digit chain so every step
//             lands one cycle after its tick. Supports clear, clamped
//             parallel load and a one-cycle wrap pulse.
//  Options  : BCD_CHAIN_TIMER_SAT_EN - saturate at all-max / all-zero instead
//             of wrapping; wrap then pulses on the step that first reaches
//             the terminal value.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_chain_timer #(
    parameter int PAIRS  = 2,
    parameter int HI_MAX = 5
) (
    input  wire logic          clk,
    input  wire logic          reset,
    bcd_chain_timer_if.slave   bus
);

    localparam int c_digits = 2 * PAIRS;
    localparam int c_width  = 8 * PAIRS;

    // Registered state
    logic [c_width-1:0]  r_bcd;
    logic                r_wrap;
    logic                r_zero;

    // Per-digit chain results
    logic [c_digits:0]   w_carry;    // w_carry[i]: digits below i are all at max
    logic [c_digits:0]   w_borrow;   // w_borrow[i]: digits below i are all zero
    logic [c_width-1:0]  w_inc;      // value after one up-step
    logic [c_width-1:0]  w_dec;      // value after one down-step
    logic [c_width-1:0]  w_clamp;    // load value with each nibble clamped

    // Next-state selection
    logic [c_width-1:0]  w_bcd_nxt;
    logic                w_wrap_nxt;
    logic                w_zero_nxt;

`ifdef BCD_CHAIN_TIMER_SAT_EN
    logic [c_width-1:0]  w_max_val;  // the all-max terminal pattern
`endif

    // The chain is seeded with an unconditional carry/borrow into digit 0;
    // the tick qualification happens in the next-state mux.
    assign w_carry[0]  = 1'b1;
    assign w_borrow[0] = 1'b1;

    generate
        for (genvar i = 0; i < c_digits; i++) begin : g_digit
            // Odd-index digits are the tens of each pair and stop at HI_MAX
            localparam logic [3:0] c_max = (i % 2 == 1) ? 4'(HI_MAX) : 4'd9;

            logic [3:0] w_d;
            logic [3:0] w_ld;

            assign w_d  = r_bcd[4*i +: 4];
            assign w_ld = bus.load_val[4*i +: 4];

            // Up direction: roll over at max and pass the carry on
            assign w_carry[i+1]    = w_carry[i] & (w_d == c_max);
            assign w_inc[4*i +: 4] = !w_carry[i]     ? w_d  :
                                     (w_d == c_max)  ? 4'd0 :
                                                       w_d + 4'd1;

            // Down direction: underflow to max and pass the borrow on
            assign w_borrow[i+1]   = w_borrow[i] & (w_d == 4'd0);
            assign w_dec[4*i +: 4] = !w_borrow[i]    ? w_d   :
                                     (w_d == 4'd0)   ? c_max :
                                                       w_d - 4'd1;

            // Out-of-range nibbles saturate so no illegal digit can be loaded
            assign w_clamp[4*i +: 4] = (w_ld > c_max) ? c_max : w_ld;

`ifdef BCD_CHAIN_TIMER_SAT_EN
            assign w_max_val[4*i +: 4] = c_max;
`endif
        end
    endgenerate

    // Next-state select with priority clear > load > tick
    always_comb begin
        w_bcd_nxt  = r_bcd;
        w_wrap_nxt = 1'b0;
        if (bus.clear) begin
            w_bcd_nxt = '0;
        end else if (bus.load) begin
            w_bcd_nxt = w_clamp;
        end else if (bus.tick) begin
`ifdef BCD_CHAIN_TIMER_SAT_EN
            // Hold at the terminal value; pulse only on the step that reaches it
            if (bus.up) begin
                if (!w_carry[c_digits]) begin
                    w_bcd_nxt  = w_inc;
                    w_wrap_nxt = (w_inc == w_max_val);
                end
            end else begin
                if (!w_borrow[c_digits]) begin
                    w_bcd_nxt  = w_dec;
                    w_wrap_nxt = (w_dec == '0);
                end
            end
`else
            // Carry/borrow out of the top digit is the full-range wrap
            if (bus.up) begin
                w_bcd_nxt  = w_inc;
                w_wrap_nxt = w_carry[c_digits];
            end else begin
                w_bcd_nxt  = w_dec;
                w_wrap_nxt = w_borrow[c_digits];
            end
`endif
        end
    end

    // Zero flag tracks the value being registered, so it follows bcd exactly
    assign w_zero_nxt = (w_bcd_nxt == '0);

    // Count, wrap and zero registers; asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bcd  <= '0;
            r_wrap <= 1'b0;
            r_zero <= 1'b1;
        end else begin
            r_bcd  <= w_bcd_nxt;
            r_wrap <= w_wrap_nxt;
            r_zero <= w_zero_nxt;
        end
    end

    assign bus.bcd  = r_bcd;
    assign bus.wrap = r_wrap;
    assign bus.zero = r_zero;

endmodule
`default_nettype wire
